// File: rtl/vmem_write_arbiter.sv
// Round-robin burst arbiter sharing the video-memory write port among N_REQ drawing engines.
// Beats outside the visible square are accepted but dropped and counted.
module vmem_write_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned VIS_MAX   = 239
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic [N_REQ-1:0]      w_req_valid,
    input  logic [16*N_REQ-1:0]   w_req_addr,
    input  logic [16*N_REQ-1:0]   w_req_data,
    output logic [N_REQ-1:0]      w_req_ready,
    input  logic                  w_freeze,
    output logic [15:0]           r_st_wadr,
    output logic [15:0]           r_st_wdata,
    output logic                  r_st_we,
    output logic [2:0]            r_grant_id,
    output logic                  r_busy,
    output logic [15:0]           r_clip_cnt
);

    localparam int unsigned GW       = 3;
    localparam int unsigned CW       = 8;
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);
    localparam logic [7:0]    VIS_LIM   = 8'(VIS_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_nxt;
    logic [CW-1:0]   beat_cnt, beat_nxt;
    logic [GW-1:0]   grant_nxt;
    logic            we_nxt;
    logic [15:0]     wadr_nxt, wdata_nxt, clip_nxt;

    logic            sel_valid;
    logic [15:0]     sel_addr, sel_data;
    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    logic            xfer, clipped;
    logic [GW-1:0]   grant_inc;

    // Granted requester's beat, and first valid requester scanning from rr_ptr
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GW'(i)) begin
                sel_valid = w_req_valid[i];
                sel_addr  = w_req_addr[16*i +: 16];
                sel_data  = w_req_data[16*i +: 16];
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!arb_found && w_req_valid[j] &&
                    ((32'(rr_ptr) + k == j) || (32'(rr_ptr) + k == j + N_REQ))) begin
                    arb_found = 1'b1;
                    arb_idx   = GW'(j);
                end
            end
        end
    end

    // Ready is decoded from registered grant state, gated only by freeze
    always_comb begin
        w_req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_req_ready[i] = (state == GRANT) && !w_freeze && (r_grant_id == GW'(i));
        end
    end

    assign xfer      = (state == GRANT) && sel_valid && !w_freeze;
    assign clipped   = (sel_addr[7:0] > VIS_LIM) || (sel_addr[15:8] > VIS_LIM);
    assign grant_inc = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + GW'(1);

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        grant_nxt = r_grant_id;
        we_nxt    = 1'b0;
        wadr_nxt  = r_st_wadr;
        wdata_nxt = r_st_wdata;
        clip_nxt  = r_clip_cnt;
        case (state)
            IDLE: begin
                if (!w_freeze && arb_found) begin
                    grant_nxt = arb_idx;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_nxt = beat_cnt + CW'(1);
                    if (clipped) begin
                        if (r_clip_cnt != 16'hFFFF) clip_nxt = r_clip_cnt + 16'd1;
                    end else begin
                        we_nxt    = 1'b1;
                        wadr_nxt  = sel_addr;
                        wdata_nxt = sel_data;
                    end
                    if (beat_cnt + CW'(1) == BURST_LIM) begin
                        state_nxt = IDLE;
                        rr_nxt    = grant_inc;
                    end
                end else if (!sel_valid && !w_freeze) begin
                    state_nxt = IDLE;
                    rr_nxt    = grant_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_st_we    <= 1'b0;
            r_st_wadr  <= '0;
            r_st_wdata <= '0;
            r_clip_cnt <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            beat_cnt   <= beat_nxt;
            r_grant_id <= grant_nxt;
            r_busy     <= (state_nxt == GRANT);
            r_st_we    <= we_nxt;
            r_st_wadr  <= wadr_nxt;
            r_st_wdata <= wdata_nxt;
            r_clip_cnt <= clip_nxt;
        end
    end

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Directed bench for vmem_write_arbiter: default, MAX_BURST=4 and MAX_BURST=1 instances share stimulus.
module tb_vmem_write_arbiter;

    logic        w_clk;
    logic        w_rst_n;
    logic [3:0]  valid;
    logic [63:0] addr;
    logic [63:0] data;
    logic        freeze;

    logic [3:0]  a_ready, b_ready, c_ready;
    logic [15:0] a_wadr, b_wadr, c_wadr;
    logic [15:0] a_wdata, b_wdata, c_wdata;
    logic        a_we, b_we, c_we;
    logic [2:0]  a_grant, b_grant, c_grant;
    logic        a_busy, b_busy, c_busy;
    logic [15:0] a_clip, b_clip, c_clip;

    int checks = 0;
    int errors = 0;

    vmem_write_arbiter #(.N_REQ(4), .MAX_BURST(16), .VIS_MAX(239)) u_a (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_req_valid(valid), .w_req_addr(addr),
        .w_req_data(data), .w_req_ready(a_ready), .w_freeze(freeze), .r_st_wadr(a_wadr),
        .r_st_wdata(a_wdata), .r_st_we(a_we), .r_grant_id(a_grant), .r_busy(a_busy),
        .r_clip_cnt(a_clip));

    vmem_write_arbiter #(.N_REQ(4), .MAX_BURST(4), .VIS_MAX(239)) u_b (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_req_valid(valid), .w_req_addr(addr),
        .w_req_data(data), .w_req_ready(b_ready), .w_freeze(freeze), .r_st_wadr(b_wadr),
        .r_st_wdata(b_wdata), .r_st_we(b_we), .r_grant_id(b_grant), .r_busy(b_busy),
        .r_clip_cnt(b_clip));

    vmem_write_arbiter #(.N_REQ(4), .MAX_BURST(1), .VIS_MAX(239)) u_c (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_req_valid(valid), .w_req_addr(addr),
        .w_req_data(data), .w_req_ready(c_ready), .w_freeze(freeze), .r_st_wadr(c_wadr),
        .r_st_wdata(c_wdata), .r_st_we(c_we), .r_grant_id(c_grant), .r_busy(c_busy),
        .r_clip_cnt(c_clip));

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    // Reset, then leave the bench 1 time unit after an edge (step 0)
    task automatic reset_dut();
        w_rst_n = 1'b0;
        valid   = '0;
        addr    = '0;
        data    = '0;
        freeze  = 1'b0;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        valid   = 4'b1111;
        addr    = 64'h0303_0202_0101_0000;
        data    = '1;
        freeze  = 1'b0;
        repeat (2) @(posedge w_clk);
        #1;
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", a_we); end
        checks++; if (a_wadr !== 16'h0000) begin errors++; $display("FAIL reset_wadr: got %h expected 0000", a_wadr); end
        checks++; if (a_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", a_wdata); end
        checks++; if (a_grant !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", a_grant); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_clip !== 16'h0000) begin errors++; $display("FAIL reset_clip: got %h expected 0000", a_clip); end
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", a_ready); end
        checks++; if ({b_busy, c_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy_bc: got %b expected 00", {b_busy, c_busy}); end
        reset_dut();
    endtask

    task automatic test_single_burst();
        logic [15:0] exp_wadr;
        logic        exp_we;
        reset_dut();
        valid       = 4'b0001;
        addr[15:0]  = 16'h0000;
        data[15:0]  = 16'hF800;
        #1;
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL sb_idle_ready: got %b expected 0000", a_ready); end
        for (int s = 1; s <= 7; s++) begin
            @(posedge w_clk); #1;
            exp_we   = (s >= 2) && (s <= 6);
            exp_wadr = (s < 2) ? 16'h0000 : ((s > 6) ? 16'h0004 : 16'(s - 2));
            checks++; if (a_busy !== (s <= 6)) begin errors++; $display("FAIL sb_busy step %0d: got %b expected %b", s, a_busy, (s <= 6)); end
            checks++; if (a_we !== exp_we) begin errors++; $display("FAIL sb_we step %0d: got %b expected %b", s, a_we, exp_we); end
            checks++; if (a_wadr !== exp_wadr) begin errors++; $display("FAIL sb_wadr step %0d: got %h expected %h", s, a_wadr, exp_wadr); end
            checks++; if (a_grant !== 3'd0) begin errors++; $display("FAIL sb_grant step %0d: got %0d expected 0", s, a_grant); end
            if (exp_we) begin
                checks++; if (a_wdata !== 16'hF800) begin errors++; $display("FAIL sb_wdata step %0d: got %h expected f800", s, a_wdata); end
            end
            if (s >= 2 && s <= 5) addr[15:0] = 16'(s - 1);
            if (s == 6) valid = 4'b0000;
            #1;
            checks++; if (a_ready !== ((s <= 6) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL sb_ready step %0d: got %b", s, a_ready); end
        end
        // rr_ptr should now favour requester 1 over requester 0
        valid        = 4'b0011;
        addr[31:16]  = 16'h0101;
        @(posedge w_clk); #1;
        checks++; if (a_grant !== 3'd1) begin errors++; $display("FAIL sb_rr_next: got %0d expected 1", a_grant); end
        valid = 4'b0000;
    endtask

    task automatic test_burst_limit();
        int          eg;
        logic        exp_busy, exp_we;
        logic [3:0]  exp_ready;
        reset_dut();
        valid        = 4'b0101;
        addr[15:0]   = 16'h0010;
        addr[47:32]  = 16'h0020;
        for (int s = 1; s <= 20; s++) begin
            @(posedge w_clk); #1;
            eg       = (((s - 1) / 5) % 2 == 1) ? 2 : 0;
            exp_busy = (s % 5) != 0;
            exp_we   = (s % 5) != 1;
            checks++; if (b_grant !== 3'(eg)) begin errors++; $display("FAIL bl_grant step %0d: got %0d expected %0d", s, b_grant, eg); end
            checks++; if (b_busy !== exp_busy) begin errors++; $display("FAIL bl_busy step %0d: got %b expected %b", s, b_busy, exp_busy); end
            checks++; if (b_we !== exp_we) begin errors++; $display("FAIL bl_we step %0d: got %b expected %b", s, b_we, exp_we); end
            if (exp_we) begin
                checks++; if (b_wadr !== ((eg == 2) ? 16'h0020 : 16'h0010)) begin errors++; $display("FAIL bl_wadr step %0d: got %h", s, b_wadr); end
            end
            exp_ready = exp_busy ? ((eg == 2) ? 4'b0100 : 4'b0001) : 4'b0000;
            #1;
            checks++; if (b_ready !== exp_ready) begin errors++; $display("FAIL bl_ready step %0d: got %b expected %b", s, b_ready, exp_ready); end
        end
        valid = 4'b0000;
    endtask

    task automatic test_freeze();
        logic        exp_we;
        logic [15:0] exp_wadr;
        reset_dut();
        valid        = 4'b0010;
        addr[31:16]  = 16'h0000;
        for (int s = 1; s <= 8; s++) begin
            @(posedge w_clk); #1;
            exp_we   = (s == 2) || (s == 3) || (s == 7);
            exp_wadr = (s <= 2) ? 16'h0000 : ((s < 7) ? 16'h0001 : 16'h0002);
            checks++; if (a_grant !== 3'd1) begin errors++; $display("FAIL fz_grant step %0d: got %0d expected 1", s, a_grant); end
            checks++; if (a_busy !== (s <= 7)) begin errors++; $display("FAIL fz_busy step %0d: got %b expected %b", s, a_busy, (s <= 7)); end
            checks++; if (a_we !== exp_we) begin errors++; $display("FAIL fz_we step %0d: got %b expected %b", s, a_we, exp_we); end
            checks++; if (a_wadr !== exp_wadr) begin errors++; $display("FAIL fz_wadr step %0d: got %h expected %h", s, a_wadr, exp_wadr); end
            addr[31:16] = (s == 1) ? 16'h0000 : ((s == 2) ? 16'h0001 : 16'h0002);
            freeze      = (s >= 3) && (s <= 5);
            valid       = ((s == 4) || (s >= 7)) ? 4'b0000 : 4'b0010;
            #1;
            checks++; if (a_ready !== (((s <= 7) && !freeze) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL fz_ready step %0d: got %b", s, a_ready); end
        end
    endtask

    task automatic test_clip();
        reset_dut();
        valid        = 4'b1000;
        addr[63:48]  = 16'hEF00;
        data[63:48]  = 16'h1234;
        for (int s = 1; s <= 4; s++) begin
            @(posedge w_clk); #1;
            checks++; if (a_we !== (s == 2)) begin errors++; $display("FAIL cl_we step %0d: got %b expected %b", s, a_we, (s == 2)); end
            checks++; if (a_wadr !== ((s >= 2) ? 16'hEF00 : 16'h0000)) begin errors++; $display("FAIL cl_wadr step %0d: got %h", s, a_wadr); end
            checks++; if (a_clip !== ((s <= 2) ? 16'd0 : 16'(s - 2))) begin errors++; $display("FAIL cl_cnt step %0d: got %0d", s, a_clip); end
            checks++; if (a_grant !== 3'd3) begin errors++; $display("FAIL cl_grant step %0d: got %0d expected 3", s, a_grant); end
            if (s == 2) begin addr[63:48] = 16'h00F0; data[63:48] = 16'h5555; end
            if (s == 3) begin addr[63:48] = 16'hF000; data[63:48] = 16'hAAAA; end
            if (s == 4) valid = 4'b0000;
            #1;
            checks++; if (a_ready !== 4'b1000) begin errors++; $display("FAIL cl_ready step %0d: got %b expected 1000", s, a_ready); end
        end
        @(posedge w_clk); #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL cl_release: got %b expected 0", a_busy); end
        checks++; if (a_wadr !== 16'hEF00) begin errors++; $display("FAIL cl_wadr_hold: got %h expected ef00", a_wadr); end
        checks++; if (a_wdata !== 16'h1234) begin errors++; $display("FAIL cl_wdata_hold: got %h expected 1234", a_wdata); end
        checks++; if (a_clip !== 16'd2) begin errors++; $display("FAIL cl_cnt_final: got %0d expected 2", a_clip); end
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        valid       = 4'b0001;
        addr[15:0]  = 16'h0101;
        @(posedge w_clk); #1;
        @(posedge w_clk); #1;
        valid        = 4'b0010;
        addr[31:16]  = 16'h0200;
        @(posedge w_clk); #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rm_release: got %b expected 0", a_busy); end
        @(posedge w_clk); #1;
        checks++; if (a_grant !== 3'd1) begin errors++; $display("FAIL rm_grant1: got %0d expected 1", a_grant); end
        @(posedge w_clk); #1; addr[31:16] = 16'h0201;
        @(posedge w_clk); #1; addr[31:16] = 16'h0202;
        @(posedge w_clk); #1;
        checks++; if ((a_we !== 1'b1) || (a_wadr !== 16'h0202)) begin errors++; $display("FAIL rm_beat3: got we=%b wadr=%h expected we=1 wadr=0202", a_we, a_wadr); end
        valid = 4'b0011;
        #2;
        w_rst_n = 1'b0;
        #1;
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL rm_async_we: got %b expected 0", a_we); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rm_async_busy: got %b expected 0", a_busy); end
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL rm_async_ready: got %b expected 0000", a_ready); end
        checks++; if (a_wadr !== 16'h0000) begin errors++; $display("FAIL rm_async_wadr: got %h expected 0000", a_wadr); end
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(posedge w_clk); #1;
        checks++; if ((a_grant !== 3'd0) || (a_busy !== 1'b1)) begin errors++; $display("FAIL rm_restart: got grant=%0d busy=%b expected grant=0 busy=1", a_grant, a_busy); end
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL rm_restart_ready: got %b expected 0001", a_ready); end
        valid = 4'b0000;
    endtask

    task automatic test_single_beat_rr();
        int          eg;
        logic        odd;
        logic [15:0] exp_wadr;
        reset_dut();
        valid = 4'b1111;
        addr  = 64'h0303_0202_0101_0000;
        for (int s = 1; s <= 10; s++) begin
            @(posedge w_clk); #1;
            odd = (s % 2) == 1;
            eg  = odd ? ((s - 1) / 2) % 4 : ((s - 2) / 2) % 4;
            exp_wadr = 16'(257 * eg);
            checks++; if (c_grant !== 3'(eg)) begin errors++; $display("FAIL rr_grant step %0d: got %0d expected %0d", s, c_grant, eg); end
            checks++; if (c_busy !== odd) begin errors++; $display("FAIL rr_busy step %0d: got %b expected %b", s, c_busy, odd); end
            checks++; if (c_we !== !odd) begin errors++; $display("FAIL rr_we step %0d: got %b expected %b", s, c_we, !odd); end
            if (!odd) begin
                checks++; if (c_wadr !== exp_wadr) begin errors++; $display("FAIL rr_wadr step %0d: got %h expected %h", s, c_wadr, exp_wadr); end
            end
            #1;
            checks++; if (c_ready !== (odd ? 4'(1 << eg) : 4'b0000)) begin errors++; $display("FAIL rr_ready step %0d: got %b", s, c_ready); end
        end
        valid = 4'b0000;
    endtask

    initial begin
        w_rst_n = 1'b0;
        valid   = '0;
        addr    = '0;
        data    = '0;
        freeze  = 1'b0;
        test_reset();
        test_single_burst();
        test_burst_limit();
        test_freeze();
        test_clip();
        test_reset_mid_burst();
        test_single_beat_rr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmem_write_arbiter.md
Name: vmem_write_arbiter

Overview:
- Shares the single write port of the 256x256x16 video memory among N_REQ drawing requesters (pattern generators, sprite and fill engines).
- Grants are round-robin and burst-oriented, with a per-grant beat limit.
- Writes are clipped to the visible 240x240 region.
- A freeze input lets the display side halt all writes, e.g. during a frame-start window.
- Sits between the drawing engines and the video memory write port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum accepted beats per grant (1..255).
- VIS_MAX, 239, largest visible x and y coordinate.

Ports:
- w_clk  input  1  main clock (100MHz).
- w_rst_n  input  1  reset, asynchronous, active-low.
- w_req_valid  input  N_REQ  per-requester beat valid.
- w_req_addr  input  16*N_REQ  per-requester address {y[7:0], x[7:0]}; requester i uses bits [16i+15:16i].
- w_req_data  input  16*N_REQ  per-requester RGB565 pixel, same packing as w_req_addr.
- w_req_ready  output  N_REQ  per-requester beat accept (combinational from registered state and w_freeze).
- w_freeze  input  1  when high, no beat is accepted and no new grant is issued.
- r_st_wadr  output  16  memory write address.
- r_st_wdata  output  16  memory write data.
- r_st_we  output  1  memory write enable, one-cycle pulse per written beat.
- r_grant_id  output  3  index of the current or last granted requester.
- r_busy  output  1  high while in GRANT state.
- r_clip_cnt  output  16  saturating count of beats dropped by clipping.

Behaviour:
- Reset (async assert, sync release) values:
  - State IDLE; rr_ptr=0; beat_cnt=0.
  - r_st_we=0, r_st_wadr=0, r_st_wdata=0.
  - r_grant_id=0, r_busy=0, r_clip_cnt=0; w_req_ready all 0.
- State IDLE:
  - w_req_ready all 0.
  - If w_freeze=0 and any valid: select the first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Load r_grant_id, set beat_cnt=0, go to GRANT.
  - The arbitration cycle transfers nothing.
- State GRANT, granted index g:
  - w_req_ready[g] = !w_freeze; all other ready bits are 0.
  - A beat transfers when w_req_valid[g] && w_req_ready[g].
- On each transfer:
  - Register the address and data into r_st_wadr/r_st_wdata on the next edge.
  - Set r_st_we=1 for exactly that following cycle, unless clipped. Write latency is 1 cycle from the accepted beat.
  - Increment beat_cnt.
- Clipping:
  - A beat is clipped if x>VIS_MAX or y>VIS_MAX.
  - A clipped beat is still accepted (ready/valid completes), but r_st_we stays 0 and r_st_wadr/r_st_wdata are not updated.
  - r_clip_cnt increments, saturating at 16'hFFFF.
- Release from GRANT to IDLE, with rr_ptr=(g+1) mod N_REQ, when either:
  - (a) w_req_valid[g]=0 and w_freeze=0 in a cycle; or
  - (b) a transfer makes beat_cnt equal MAX_BURST.
- Freeze while in GRANT:
  - The grant is held; beat_cnt and all outputs are held; r_st_we=0 from the next cycle.
  - Valid dropping during freeze does not release the grant.
- Between transfers, r_st_wadr/r_st_wdata hold their last values and r_st_we=0.
- Requester obligations: a requester must hold addr/data stable while valid and not ready. The arbiter does not check this.
- Valid on non-granted requesters is ignored until their turn.
- Fairness: after release, the releasing requester has the lowest priority. Worst-case wait for a continuously valid requester is (N_REQ-1)*(MAX_BURST+1) non-frozen cycles.
- Reset mid-burst: all outputs return to reset values immediately; any beat in flight is not written.
- r_busy = (state==GRANT).

Test Plan:
- Only req0 valid, 5 beats at addrs 0x0000..0x0004, data 0xF800:
  - grant on cycle 1, ready from cycle 1;
  - r_st_we pulses 5 cycles, each 1 cycle after its beat;
  - release when valid drops; rr_ptr=1.
- req0 and req2 valid continuously, MAX_BURST=4:
  - grants alternate 0,2,0,2;
  - each grant gives exactly 4 writes followed by 1 idle arbitration cycle.
- req1 bursting, w_freeze high for 3 cycles after beat 2:
  - ready[1]=0 and r_st_we=0 for those 3 cycles;
  - beat 3 is accepted on the first cycle after freeze drops;
  - grant_id stays 1 throughout.
- req3 writes addrs 0xEF00 (x=0,y=239), 0x00F0 (x=240), 0xF000 (y=240):
  - first beat written;
  - last two accepted, r_st_we=0, r_clip_cnt=2;
  - r_st_wadr stays 0xEF00.
- Assert w_rst_n=0 asynchronously mid-burst (beat 3 of 8):
  - r_st_we=0, ready=0 and r_busy=0 immediately, before the next edge;
  - after release, arbitration restarts from req0.
- All 4 requesters valid, MAX_BURST=1:
  - grant order 0,1,2,3,0;
  - one write every 2 cycles.
